// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, flag bit
// positions inside the 4-bit flags word, and the controller state type.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SLL   = 4'b0001;
   localparam logic [3:0] OP_SLT   = 4'b0010;
   localparam logic [3:0] OP_SLTU  = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SRL   = 4'b0101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_AND   = 4'b0111;
   localparam logic [3:0] OP_SUB   = 4'b1000;
   localparam logic [3:0] OP_SRA   = 4'b1001;
   localparam logic [3:0] OP_ADDU  = 4'b1010;
   localparam logic [3:0] OP_SUBU  = 4'b1011;
   localparam logic [3:0] OP_MUL   = 4'b1100;
   localparam logic [3:0] OP_MULHU = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;
   localparam logic [3:0] OP_REMU  = 4'b1111;

   localparam int FLAG_ZF = 3;
   localparam int FLAG_SF = 2;
   localparam int FLAG_CF = 1;
   localparam int FLAG_OF = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ops 1100-1111 belong to the iterative multiply/divide group.
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op[3] && op[2]);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU: valid/ready on the operand
// side and valid/ready on the result side. The master issues operations,
// the slave (the ALU) returns results.
interface alu_seq_if #(parameter int WIDTH = 32);

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] lhs;
   logic [WIDTH-1:0] rhs;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic [3:0]       flags;
   logic             op_err;

   modport master (
      output in_valid, op, lhs, rhs, out_ready,
      input  in_ready, out_valid, res, flags, op_err
   );

   modport slave (
      input  in_valid, op, lhs, rhs, out_ready,
      output in_ready, out_valid, res, flags, op_err
   );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide unit, present only when ALU_SEQ_MULDIV_EN is
// defined. One bit per cycle, WIDTH cycles per operation:
//   mul/mulhu : shift-add, {acc_hi,acc_lo} ends up holding the 2*WIDTH product
//   divu/remu : restoring division, acc_lo = quotient, acc_hi = remainder
// A zero divisor needs no special case: every trial subtraction succeeds, so
// the quotient fills with ones and the remainder shifts back to the dividend.
`ifdef ALU_SEQ_MULDIV_EN
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] lhs,
   input  logic [WIDTH-1:0] rhs,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] ITERS = (SHW+1)'(WIDTH);

   logic             running;
   logic [SHW:0]     cnt;
   logic [3:0]       op_p0;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic             op_div;

   assign op_div = (op_p0 == OP_DIVU) || (op_p0 == OP_REMU);
   assign done   = running && (cnt == ITERS);

   // One step of both algorithms; only the one matching op_p0 is used.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd};
   end

   // Iteration control: counts WIDTH steps after start, done holds for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
      end else if (done) begin
         running <= 1'b0;
      end else if (running) begin
         cnt <= cnt + (SHW+1)'(1);
      end
   end

   // Operand capture and shift registers; data only, no reset needed.
   always_ff @(posedge clk) begin
      if (start) begin
         op_p0  <= op;
         acc_hi <= '0;
         if ((op == OP_DIVU) || (op == OP_REMU)) begin
            acc_lo <= lhs;
            opnd   <= rhs;
         end else begin
            acc_lo <= rhs;
            opnd   <= lhs;
         end
      end else if (running && !done) begin
         if (op_div) begin
            if (!div_trial[WIDTH]) begin
               acc_hi <= div_trial[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
               acc_hi <= div_shift[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
         end
      end
   end

   // mul/divu take the low half, mulhu/remu the high half.
   always_comb begin
      case (op_p0)
         OP_MUL, OP_DIVU: result = acc_lo;
         default:         result = acc_hi;
      endcase
   end

endmodule
`endif

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides. Simple ops complete one cycle
// after accept; with ALU_SEQ_MULDIV_EN defined, ops 1100-1111 run on the
// iterative unit (WIDTH+1 cycles), otherwise they return op_err with res=0.
// A finished result is held until the consumer takes it; a new op may be
// accepted in the same cycle the old result leaves.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   alu_seq_if.slave  bus
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state;
   logic             out_valid_q;
   logic [WIDTH-1:0] res_q;
   logic [3:0]       flags_q;
   logic             err_q;

   logic             in_ready;
   logic             accept;
   logic             take_md;

   logic signed [WIDTH-1:0] lhs_s;
   logic signed [WIDTH-1:0] rhs_s;
   logic [WIDTH:0]          sum;
   logic [WIDTH:0]          diff;
   logic [SHW-1:0]          shamt;
   logic [WIDTH-1:0]        s_res;
   logic                    s_cf;
   logic                    s_of;
   logic                    s_err;

   function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                             input logic cf, input logic of);
      logic [3:0] f;
      f[FLAG_ZF] = (r == '0);
      f[FLAG_SF] = r[WIDTH-1];
      f[FLAG_CF] = cf;
      f[FLAG_OF] = of;
      return f;
   endfunction

   assign in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.res       = res_q;
   assign bus.flags     = flags_q;
   assign bus.op_err    = err_q;

   assign lhs_s = bus.lhs;
   assign rhs_s = bus.rhs;
   assign sum   = {1'b0, bus.lhs} + {1'b0, bus.rhs};
   assign diff  = {1'b0, bus.lhs} - {1'b0, bus.rhs};
   assign shamt = bus.rhs[SHW-1:0];

`ifdef ALU_SEQ_MULDIV_EN
   logic             md_done;
   logic [WIDTH-1:0] md_res;

   assign take_md = is_muldiv(bus.op);

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (accept && take_md),
      .op     (bus.op),
      .lhs    (bus.lhs),
      .rhs    (bus.rhs),
      .done   (md_done),
      .result (md_res)
   );
`else
   assign take_md = 1'b0;
`endif

   // Single-cycle datapath for everything except the mul/div group.
   always_comb begin
      s_res = '0;
      s_cf  = 1'b0;
      s_of  = 1'b0;
      s_err = 1'b0;
      case (bus.op)
         OP_ADD, OP_ADDU: begin
            s_res = sum[WIDTH-1:0];
            s_cf  = sum[WIDTH];
            s_of  = (bus.op == OP_ADD) && (bus.lhs[WIDTH-1] == bus.rhs[WIDTH-1])
                    && (sum[WIDTH-1] != bus.lhs[WIDTH-1]);
         end
         OP_SUB, OP_SUBU: begin
            s_res = diff[WIDTH-1:0];
            s_cf  = diff[WIDTH];
            s_of  = (bus.op == OP_SUB) && (bus.lhs[WIDTH-1] != bus.rhs[WIDTH-1])
                    && (diff[WIDTH-1] != bus.lhs[WIDTH-1]);
         end
         OP_SLL:  s_res = bus.lhs << shamt;
         OP_SRL:  s_res = bus.lhs >> shamt;
         OP_SRA:  s_res = lhs_s >>> shamt;
         OP_SLT:  s_res = {{(WIDTH-1){1'b0}}, (lhs_s < rhs_s)};
         OP_SLTU: s_res = {{(WIDTH-1){1'b0}}, (bus.lhs < bus.rhs)};
         OP_XOR:  s_res = bus.lhs ^ bus.rhs;
         OP_OR:   s_res = bus.lhs | bus.rhs;
         OP_AND:  s_res = bus.lhs & bus.rhs;
         default: begin
`ifndef ALU_SEQ_MULDIV_EN
            s_err = 1'b1;
`endif
         end
      endcase
   end

   // Controller: accept, wait for the iterative unit, hold result until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         flags_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if ((state == DONE) && bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
               if (accept) begin
                  if (take_md) begin
                     state       <= BUSY;
                     out_valid_q <= 1'b0;
                  end else begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                     res_q       <= s_res;
                     flags_q     <= make_flags(s_res, s_cf, s_of);
                     err_q       <= s_err;
                  end
               end
            end
`ifdef ALU_SEQ_MULDIV_EN
            BUSY: begin
               if (md_done) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  res_q       <= md_res;
                  flags_q     <= make_flags(md_res, 1'b0, 1'b0);
                  err_q       <= 1'b0;
               end
            end
`endif
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32). Works with ALU_SEQ_MULDIV_EN
// defined or not. A reference model computes results from the opcode rules;
// a monitor compares every result, its latency, in_ready and hold stability.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 32;
`ifdef ALU_SEQ_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   rdy_mode = 0;

   typedef struct {
      logic [31:0] r;
      logic [3:0]  f;
      logic        e;
      int          acc;
      int          lat;
   } exp_t;
   exp_t q[$];

   alu_seq_if #(.WIDTH(W)) bus();

   alu_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input bit ok, input string name,
                               input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Reference model: plain integer arithmetic on the opcode rules.
   function automatic void model(input logic [3:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] r,
                                 output logic [3:0] f, output logic e);
      longint      sa, sb, s;
      logic [63:0] wide;
      logic        cf, of;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      cf = 1'b0; of = 1'b0; e = 1'b0; r = '0;
      case (o)
         OP_ADD, OP_ADDU: begin
            wide = {32'b0, a} + {32'b0, b};
            r = wide[31:0]; cf = wide[32];
            s = sa + sb;
            of = (o == OP_ADD) && (s > SMAX || s < SMIN);
         end
         OP_SUB, OP_SUBU: begin
            r = a - b; cf = (a < b);
            s = sa - sb;
            of = (o == OP_SUB) && (s > SMAX || s < SMIN);
         end
         OP_SLL:  r = a << b[4:0];
         OP_SRL:  r = a >> b[4:0];
         OP_SRA:  r = $signed(a) >>> b[4:0];
         OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
         OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         OP_XOR:  r = a ^ b;
         OP_OR:   r = a | b;
         OP_AND:  r = a & b;
         default: begin
            if (MD) begin
               wide = {32'b0, a} * {32'b0, b};
               case (o)
                  OP_MUL:   r = wide[31:0];
                  OP_MULHU: r = wide[63:32];
                  OP_DIVU:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                  default:  r = (b == 0) ? a : a % b;
               endcase
            end else begin
               r = '0; e = 1'b1;
            end
         end
      endcase
      f = {(r == 32'd0), r[31], cf, of};
   endfunction

   // Compare process: runs on every falling edge.
   task automatic monitor();
      bit          seen = 1'b0, prev_hold = 1'b0, was_rst = 1'b0;
      logic [31:0] pr, mr;
      logic [3:0]  pf, mf;
      logic        pe, me;
      int          qn;
      exp_t        x;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete(); seen = 1'b0; prev_hold = 1'b0; was_rst = 1'b1;
         end else begin
            if (was_rst) begin
               chk(bus.out_valid == 1'b0, "rst_out_valid", 64'(bus.out_valid), 64'd0);
               chk(bus.in_ready == 1'b1, "rst_in_ready", 64'(bus.in_ready), 64'd1);
               chk(bus.res == 32'd0, "rst_res", 64'(bus.res), 64'd0);
               chk(bus.flags == 4'd0, "rst_flags", 64'(bus.flags), 64'd0);
               chk(bus.op_err == 1'b0, "rst_op_err", 64'(bus.op_err), 64'd0);
               was_rst = 1'b0;
            end
            if (prev_hold)
               chk(bus.out_valid && bus.res == pr && bus.flags == pf && bus.op_err == pe,
                   "hold_stable", {bus.res, 27'd0, bus.flags, bus.op_err}, {pr, 27'd0, pf, pe});
            qn = q.size();
            chk(bus.in_ready == ((qn == 0) || (bus.out_valid && bus.out_ready)),
                "in_ready", 64'(bus.in_ready), 64'((qn == 0) || (bus.out_valid && bus.out_ready)));
            if (bus.out_valid) begin
               chk(qn != 0, "spurious_out_valid", 64'(qn), 64'd1);
               if (qn != 0) begin
                  if (!seen) begin
                     seen = 1'b1;
                     chk(bus.res == q[0].r, "res", 64'(bus.res), 64'(q[0].r));
                     chk(bus.flags == q[0].f, "flags", 64'(bus.flags), 64'(q[0].f));
                     chk(bus.op_err == q[0].e, "op_err", 64'(bus.op_err), 64'(q[0].e));
                     chk(cyc - q[0].acc == q[0].lat, "latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                  end
                  if (bus.out_ready) begin
                     void'(q.pop_front());
                     seen = 1'b0;
                  end
               end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            pr = bus.res; pf = bus.flags; pe = bus.op_err;
            if (bus.in_valid && bus.in_ready) begin
               model(bus.op, bus.lhs, bus.rhs, mr, mf, me);
               x.r = mr; x.f = mf; x.e = me; x.acc = cyc;
               x.lat = (MD && bus.op >= OP_MUL) ? W + 1 : 1;
               q.push_back(x);
            end
         end
      end
   endtask

   task automatic drive_ready();
      case (rdy_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   task automatic step();
      @(posedge clk); #1;
      drive_ready();
   endtask

   task automatic send(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, output int tries);
      bit took;
      bus.in_valid = 1'b1; bus.op = o; bus.lhs = a; bus.rhs = b;
      tries = 0;
      do begin
         @(negedge clk);
         took = bus.in_ready;
         @(posedge clk); #1;
         drive_ready();
         tries++;
      end while (!took && tries < 200);
      if (!took) chk(took, "accept_timeout", 64'(tries), 64'd200);
      bus.in_valid = 1'b0;
      bus.op  = 4'($urandom_range(0, 15));
      bus.lhs = $urandom;
      bus.rhs = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || bus.out_valid) && n < 300) begin
         step();
         n++;
      end
      chk(n < 300, "drain_timeout", 64'(n), 64'd300);
   endtask

   // Pins the model to a hand-computed value, then runs the op on the DUT.
   task automatic directed(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [3:0] ef, input logic ee,
                           input string nm);
      logic [31:0] r;
      logic [3:0]  f;
      logic        e;
      int          t;
      model(o, a, b, r, f, e);
      chk(r == er && f == ef && e == ee, nm, {r, 27'd0, f, e}, {er, 27'd0, ef, ee});
      send(o, a, b, t);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] edges [5];
      edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'h7FFF_FFFF;
      edges[3] = 32'h8000_0000; edges[4] = 32'hFFFF_FFFF;
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 40));
         1:       return edges[$urandom_range(0, 4)];
         default: return $urandom;
      endcase
   endfunction

   task automatic run_tests();
      int t;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.op = '0; bus.lhs = '0; bus.rhs = '0;
      bus.out_ready = 1'b1; rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      directed(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, 1'b0, "pin_add_carry");
      directed(OP_ADD,  32'h7FFF_FFFF, 32'h1000_0003, 32'h9000_0002, 4'b0101, 1'b0, "pin_add_ovf");
      directed(OP_ADDU, 32'h7FFF_FFFF, 32'h1000_0003, 32'h9000_0002, 4'b0100, 1'b0, "pin_addu");
      directed(OP_SUB,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0110, 1'b0, "pin_sub");
      directed(OP_SRA,  32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 4'b0100, 1'b0, "pin_sra");
      directed(OP_SLT,  32'hFFFF_0000, 32'h0003_0001, 32'h0000_0001, 4'b0000, 1'b0, "pin_slt");
      directed(OP_SLTU, 32'hFFFF_0000, 32'h0003_0001, 32'h0000_0000, 4'b1000, 1'b0, "pin_sltu");
      directed(OP_SLL,  32'h000F_0000, 32'hFFFF_FFE2, 32'h003C_0000, 4'b0000, 1'b0, "pin_sll");
      directed(OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001, 1'b0, "pin_sub_ovf");
`ifdef ALU_SEQ_MULDIV_EN
      directed(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0100, 1'b0, "pin_mulhu");
      directed(OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0100, 1'b0, "pin_divu0");
      directed(OP_REMU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 4'b0000, 1'b0, "pin_remu0");
      directed(OP_MUL,   32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 4'b0000, 1'b0, "pin_mul");
`else
      directed(OP_MUL,   32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 4'b1000, 1'b1, "pin_op_err");
      directed(OP_REMU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 4'b1000, 1'b1, "pin_op_err_remu");
`endif
      drain();

      // Consumer stalls for 5 cycles; a new op waits, then enters as ready rises.
      rdy_mode = 2;
      bus.out_ready = 1'b0;
      send(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, t);
      chk(bus.out_valid == 1'b1, "stall_out_valid", 64'(bus.out_valid), 64'd1);
      bus.in_valid = 1'b1; bus.op = OP_SUB; bus.lhs = 32'h10; bus.rhs = 32'h20;
      repeat (5) begin
         @(negedge clk);
         chk(bus.in_ready == 1'b0, "stall_in_ready", 64'(bus.in_ready), 64'd0);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      send(OP_SUB, 32'h10, 32'h20, t);
      chk(t == 1, "accept_on_ready_rise", 64'(t), 64'd1);
      rdy_mode = 0;
      drain();

      // Reset while an operation is in flight, then a normal op.
`ifdef ALU_SEQ_MULDIV_EN
      send(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, t);
`else
      send(OP_ADD, 32'hDEAD_BEEF, 32'h1234_5678, t);
`endif
      repeat (10) step();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      send(OP_DIVU, 32'd1000, 32'd7, t);
`else
      send(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, t);
`endif
      drain();

      // Randomized traffic with a random consumer.
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         send(4'($urandom_range(0, 15)), pick(), pick(), t);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      end
      rdy_mode = 0;
      drive_ready();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   initial begin
      fork
         monitor();
         run_tests();
      join_any
   end

endmodule
